// File: rtl/msg_scroll_driver_pkg.sv
// Shared character codes and types for the message scroll driver.
// Codes match the str_to_7seg decoder table.
package msg_scroll_driver_pkg;

  localparam int CHAR_W = 5;

  typedef logic [CHAR_W-1:0] char_t;

  localparam char_t CHAR_0     = 5'd0;
  localparam char_t CHAR_9     = 5'd9;
  localparam char_t CHAR_A     = 5'd10;
  localparam char_t CHAR_SPACE = 5'd27;
  localparam char_t CHAR_BLANK = 5'd28;

endpackage

// File: rtl/msg_scroll_driver_tick_gen.sv
// Free-running divider: counts while en, emits a 1-cycle tick
// on the last count and returns to zero.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/msg_scroll_driver.sv
// Message buffer with multiplexed digit scan and left scroll,
// feeding character codes to the 7-segment decoder.
module msg_scroll_driver
  import msg_scroll_driver_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int MSG_LEN    = 16,
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]          wr_char,
  output logic [CHAR_W-1:0]          char_code,
  output logic [DIGITS-1:0]          digit_sel,
  output logic [$clog2(MSG_LEN)-1:0] scroll_pos,
  output logic                       wrap
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int IW = $clog2(DIGITS);
  localparam logic [AW:0] LEN = (AW+1)'(MSG_LEN);

  char_t          msg_buf [MSG_LEN];
  logic           scan_tick;
  logic           scroll_tick;
  logic [IW-1:0]  digit_idx;
  logic [IW-1:0]  idx_nx;
  logic [AW-1:0]  pos_nx;
  logic [DIGITS-1:0] sel_nx;
  logic [AW:0]    sum;
  logic [AW-1:0]  rd_idx;
  logic           wr_ok;

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (scan_tick)
  );

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (scroll_tick)
  );

  // Read index uses the post-edge digit and scroll position
  always_comb begin
    idx_nx = digit_idx;
    pos_nx = scroll_pos;
    sel_nx = digit_sel;
    if (scan_tick) begin
      idx_nx = (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      sel_nx = {digit_sel[DIGITS-2:0], digit_sel[DIGITS-1]};
    end
    if (scroll_tick) begin
      pos_nx = (scroll_pos == AW'(MSG_LEN - 1)) ? '0 : scroll_pos + 1'b1;
    end
    sum    = {1'b0, pos_nx} + (AW+1)'(idx_nx);
    rd_idx = AW'((sum >= LEN) ? sum - LEN : sum);
    wr_ok  = wr_en && ({1'b0, wr_addr} < LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_idx  <= '0;
      digit_sel  <= DIGITS'(1);
      scroll_pos <= '0;
      wrap       <= 1'b0;
      char_code  <= CHAR_SPACE;
    end else begin
      digit_idx  <= idx_nx;
      digit_sel  <= sel_nx;
      scroll_pos <= pos_nx;
      wrap       <= scroll_tick && (pos_nx == '0);
      char_code  <= msg_buf[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_buf[i] <= CHAR_SPACE;
      end
    end else if (wr_ok) begin
      msg_buf[wr_addr] <= wr_char;
    end
  end

endmodule
